// File: rtl/apb_bridge_pkg.sv
// Shared types and width defaults for the AHB-to-APB bridge.
package apb_bridge_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 32;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_SEL_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_RENABLE,
        ST_WRITE,
        ST_WENABLE,
        ST_WRITEP,
        ST_WENABLEP
    } bridge_state_e;

endpackage

// File: rtl/apb_controller.sv
// AHB-to-APB bridge FSM: turns qualified AHB transfers into APB setup/enable
// sequences and stalls the AHB master while a transfer is in flight.
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned SEL_W  = DEFAULT_SEL_W
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [SEL_W-1:0]  tempselx,
    input  logic [DATA_W-1:0] Prdata,
    output logic              Pwrite,
    output logic              Penable,
    output logic [SEL_W-1:0]  Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata
);

    bridge_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [SEL_W-1:0]  sel_q;
    logic              write_q;

    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [SEL_W-1:0]  psel_q, psel_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              penable_q, penable_d;
    logic              hready_q, hready_d;

    // AHB address pipeline: only accept a new address phase when not stalling.
    logic capture;
    assign capture = valid & hready_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid) state_d = Hwrite ? ST_WWAIT : ST_READ;
                else       state_d = ST_IDLE;
            end
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_d = ST_RENABLE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!write_q)   state_d = ST_READ;
                else if (valid) state_d = ST_WRITEP;
                else            state_d = ST_WRITE;
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // APB outputs are decided by the state being entered.
    always_comb begin
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        penable_d = 1'b0;
        hready_d  = 1'b1;
        case (state_d)
            ST_READ: begin
                // A read queued behind a write was already captured into addr_q.
                if (state_q == ST_WENABLEP) begin
                    paddr_d = addr_q;
                    psel_d  = sel_q;
                end else begin
                    paddr_d = Haddr;
                    psel_d  = tempselx;
                end
                pwrite_d = 1'b0;
                hready_d = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                paddr_d  = addr_q;
                psel_d   = sel_q;
                pwdata_d = Hwdata;
                pwrite_d = 1'b1;
                hready_d = (state_d != ST_WRITEP);
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                penable_d = 1'b1;
            end
            default: begin
                psel_d = '0;
            end
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            sel_q     <= '0;
            write_q   <= 1'b0;
            paddr_q   <= '0;
            psel_q    <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
            hready_q  <= hready_d;
            if (capture) begin
                addr_q  <= Haddr;
                sel_q   <= tempselx;
                write_q <= Hwrite;
            end
        end
    end

    assign Paddr     = paddr_q;
    assign Pselx     = psel_q;
    assign Pwdata    = pwdata_q;
    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Hreadyout = hready_q;
    assign Hrdata    = Prdata;

endmodule
